// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage: op codes, ID/EX bus field
// positions, NZCV bit indices and control bundles.
package ex_pkg;

    localparam int unsigned DW     = 8;
    localparam int unsigned BUS_W  = 69;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned SQ_W   = 2;
    localparam int unsigned MCNT_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
    localparam logic [OP_W-1:0] OP_AND   = 4'h2;
    localparam logic [OP_W-1:0] OP_OR    = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
    localparam logic [OP_W-1:0] OP_MOV   = 4'h5;
    localparam logic [OP_W-1:0] OP_LSL   = 4'h6;
    localparam logic [OP_W-1:0] OP_LSR   = 4'h7;
    localparam logic [OP_W-1:0] OP_MUL   = 4'h8;
    localparam logic [OP_W-1:0] OP_CMP   = 4'h9;
    localparam logic [OP_W-1:0] OP_FLAGS = 4'hF;

    // ID/EX bus field LSB positions
    localparam int unsigned F_OP    = 0;
    localparam int unsigned F_S1    = 4;
    localparam int unsigned F_S2    = 12;
    localparam int unsigned F_SD    = 20;
    localparam int unsigned F_DEST  = 28;
    localparam int unsigned F_CTRL  = 32;
    localparam int unsigned F_COND  = 36;
    localparam int unsigned F_FLD   = 45;
    localparam int unsigned F_BR    = 49;
    localparam int unsigned F_RVOFF = 50;
    localparam int unsigned F_RVBR  = 58;
    localparam int unsigned F_PC    = 59;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic reg_write;
        logic rd_en;
        logic wr_en;
        logic mem_to_reg;
    } reg_ctrl_t;

    typedef struct packed {
        logic c_zero;
        logic c_neg;
        logic c_ovf;
        logic c_always;
        logic c_update;
    } cond_t;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} mul_state_t;

endpackage

// File: rtl/ex_if.sv
// ID/EX input bus, upstream stall and EX/MEM result bundle of the execute stage.
interface ex_if;
    import ex_pkg::*;

    logic [BUS_W-1:0]  idex_bus;
    logic              ex_busy;
    logic [DW-1:0]     alu_result;
    logic [DW-1:0]     mem_data;
    logic [REG_W-1:0]  mem_dest;
    logic [3:0]        mem_ctrl;
    logic              mem_valid;
    logic              branch_taken;
    logic [DW-1:0]     branch_target;
    logic [FLAG_W-1:0] flags;

    modport master (output idex_bus,
                    input  ex_busy, alu_result, mem_data, mem_dest, mem_ctrl,
                           mem_valid, branch_taken, branch_target, flags);

    modport slave  (input  idex_bus,
                    output ex_busy, alu_result, mem_data, mem_dest, mem_ctrl,
                           mem_valid, branch_taken, branch_target, flags);
endinterface

// File: rtl/ex_alu.sv
// Combinational 8-bit ALU; returns the result and the NZCV the op would produce
// (C and V pass through for ops that do not define them; op 8 is a NOP here).
module ex_alu
    import ex_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DW-1:0]     s1,
    input  logic [DW-1:0]     s2,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [DW-1:0]     result,
    output logic [FLAG_W-1:0] nzcv
);

    logic [DW:0] sum;
    logic [DW:0] diff;
    logic        c_new;
    logic        v_new;
    logic        nz_upd;

    always_comb begin
        sum    = {1'b0, s1} + {1'b0, s2};
        diff   = {1'b0, s1} + {1'b0, ~s2} + (DW+1)'(1);
        result = '0;
        c_new  = flags_in[FLAG_C];
        v_new  = flags_in[FLAG_V];
        nz_upd = 1'b1;
        case (op)
            OP_ADD: begin
                result = sum[DW-1:0];
                c_new  = sum[DW];
                v_new  = (s1[DW-1] == s2[DW-1]) && (sum[DW-1] != s1[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                result = diff[DW-1:0];
                c_new  = diff[DW];
                v_new  = (s1[DW-1] != s2[DW-1]) && (diff[DW-1] != s1[DW-1]);
            end
            OP_AND:  result = s1 & s2;
            OP_OR:   result = s1 | s2;
            OP_XOR:  result = s1 ^ s2;
            OP_MOV:  result = s2;
            OP_LSL:  result = s1 << s2[2:0];
            OP_LSR:  result = s1 >> s2[2:0];
            default: nz_upd = 1'b0;
        endcase
        nzcv = flags_in;
        if (nz_upd) begin
            nzcv[FLAG_N] = result[DW-1];
            nzcv[FLAG_Z] = (result == '0);
            nzcv[FLAG_C] = c_new;
            nzcv[FLAG_V] = v_new;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: conditional ALU op, branch resolution, branch-shadow squash and
// EX/MEM registers. Define EX_MUL_EN to build the 8-cycle shift-add multiplier.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned SQUASH_SLOTS = 1
)
(
    input  logic nclk,
    input  logic rst,
    ex_if.slave  ex
);

    logic [OP_W-1:0]   op;
    logic [DW-1:0]     s1, s2, sd, rv_off, pc;
    logic [REG_W-1:0]  dest;
    logic [FLAG_W-1:0] flags_load;
    reg_ctrl_t         ctrl_in, ctrl_v;
    cond_t             cond;
    logic              br, rv_br;
    logic              unused_bits;

    assign op          = ex.idex_bus[F_OP +: OP_W];
    assign s1          = ex.idex_bus[F_S1 +: DW];
    assign s2          = ex.idex_bus[F_S2 +: DW];
    assign sd          = ex.idex_bus[F_SD +: DW];
    assign dest        = ex.idex_bus[F_DEST +: REG_W];
    assign ctrl_in     = reg_ctrl_t'(ex.idex_bus[F_CTRL +: 4]);
    assign cond        = cond_t'(ex.idex_bus[F_COND +: 5]);
    assign flags_load  = ex.idex_bus[F_FLD +: FLAG_W];
    assign br          = ex.idex_bus[F_BR];
    assign rv_off      = ex.idex_bus[F_RVOFF +: DW];
    assign rv_br       = ex.idex_bus[F_RVBR];
    assign pc          = ex.idex_bus[F_PC +: DW];
    assign unused_bits = ^{ex.idex_bus[44:41], ex.idex_bus[68:67]};

    logic [DW-1:0]     alu_result_q, alu_result_d, mem_data_q, mem_data_d;
    logic [REG_W-1:0]  mem_dest_q, mem_dest_d;
    reg_ctrl_t         mem_ctrl_q, mem_ctrl_d;
    logic              mem_valid_q, mem_valid_d, branch_taken_q, branch_taken_d;
    logic [DW-1:0]     branch_target_q, branch_target_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [SQ_W-1:0]   squash_q, squash_d;
    logic [DW-1:0]     alu_res_c;
    logic [FLAG_W-1:0] alu_nzcv_c;
    logic              exec_c, busy_c;

`ifdef EX_MUL_EN
    mul_state_t        state_q, state_d;
    logic [MCNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d, mul_sum_c;
    logic [DW-1:0]     mul_data_q, mul_data_d;
    logic [REG_W-1:0]  mul_dest_q, mul_dest_d;
    reg_ctrl_t         mul_ctrl_q, mul_ctrl_d;
    logic              mul_upd_q, mul_upd_d;
`endif

    ex_alu u_alu (
        .op       (op),
        .s1       (s1),
        .s2       (s2),
        .flags_in (flags_q),
        .result   (alu_res_c),
        .nzcv     (alu_nzcv_c)
    );

    // Condition check against registered flags; squashed slots never execute
    assign exec_c = (cond.c_always | (cond.c_zero & flags_q[FLAG_Z]) |
                     (cond.c_neg & flags_q[FLAG_N]) | (cond.c_ovf & flags_q[FLAG_V])) &
                    (squash_q == '0);

    always_comb begin
        busy_c          = 1'b0;
        alu_result_d    = '0;
        mem_data_d      = '0;
        mem_dest_d      = '0;
        mem_ctrl_d      = '0;
        mem_valid_d     = 1'b0;
        branch_taken_d  = 1'b0;
        branch_target_d = '0;
        flags_d         = flags_q;
        squash_d        = squash_q;
        ctrl_v          = ctrl_in;
        if (op == OP_CMP) ctrl_v.reg_write = 1'b0;

        if (squash_q != '0) squash_d = squash_q - SQ_W'(1);
        if (exec_c) begin
            mem_valid_d  = 1'b1;
            alu_result_d = alu_res_c;
            mem_data_d   = sd;
            mem_dest_d   = dest;
            mem_ctrl_d   = ctrl_v;
            if (cond.c_update) flags_d = (op == OP_FLAGS) ? flags_load : alu_nzcv_c;
            if (rv_br) begin
                if (s1 == s2) begin
                    branch_taken_d  = 1'b1;
                    branch_target_d = pc + rv_off;
                end
            end else if (br) begin
                branch_taken_d  = 1'b1;
                branch_target_d = s2;
            end
            if (branch_taken_d) squash_d = SQ_W'(SQUASH_SLOTS);
        end

`ifdef EX_MUL_EN
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        acc_d      = acc_q;
        mul_data_d = mul_data_q;
        mul_dest_d = mul_dest_q;
        mul_ctrl_d = mul_ctrl_q;
        mul_upd_d  = mul_upd_q;
        mul_sum_c  = acc_q + (mul_b_q[0] ? mul_a_q : '0);

        // Issue and step cycles emit a bubble; the held bus is dropped at count 7
        if ((state_q == S_MUL) || (exec_c && (op == OP_MUL))) begin
            alu_result_d    = '0;
            mem_data_d      = '0;
            mem_dest_d      = '0;
            mem_ctrl_d      = '0;
            mem_valid_d     = 1'b0;
            branch_taken_d  = 1'b0;
            branch_target_d = '0;
            flags_d         = flags_q;
            squash_d        = squash_q;
        end

        if (state_q == S_MUL) begin
            busy_c  = (cnt_q != MCNT_W'(7));
            acc_d   = mul_sum_c;
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q + MCNT_W'(1);
            if (cnt_q == MCNT_W'(7)) begin
                state_d      = S_IDLE;
                mem_valid_d  = 1'b1;
                alu_result_d = mul_sum_c;
                mem_data_d   = mul_data_q;
                mem_dest_d   = mul_dest_q;
                mem_ctrl_d   = mul_ctrl_q;
                if (mul_upd_q) begin
                    flags_d[FLAG_N] = mul_sum_c[DW-1];
                    flags_d[FLAG_Z] = (mul_sum_c == '0);
                end
            end
        end else if (exec_c && (op == OP_MUL)) begin
            busy_c     = 1'b1;
            state_d    = S_MUL;
            cnt_d      = '0;
            mul_a_d    = s1;
            mul_b_d    = s2;
            acc_d      = '0;
            mul_data_d = sd;
            mul_dest_d = dest;
            mul_ctrl_d = ctrl_in;
            mul_upd_d  = cond.c_update;
        end
`endif
    end

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            alu_result_q    <= '0;
            mem_data_q      <= '0;
            mem_dest_q      <= '0;
            mem_ctrl_q      <= '0;
            mem_valid_q     <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            flags_q         <= '0;
            squash_q        <= '0;
        end else begin
            alu_result_q    <= alu_result_d;
            mem_data_q      <= mem_data_d;
            mem_dest_q      <= mem_dest_d;
            mem_ctrl_q      <= mem_ctrl_d;
            mem_valid_q     <= mem_valid_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            flags_q         <= flags_d;
            squash_q        <= squash_d;
        end
    end

`ifdef EX_MUL_EN
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            mul_data_q <= '0;
            mul_dest_q <= '0;
            mul_ctrl_q <= '0;
            mul_upd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            acc_q      <= acc_d;
            mul_data_q <= mul_data_d;
            mul_dest_q <= mul_dest_d;
            mul_ctrl_q <= mul_ctrl_d;
            mul_upd_q  <= mul_upd_d;
        end
    end
`endif

    // Stall is dropped while reset is held so a pending MUL bus cannot keep it high
    assign ex.ex_busy       = busy_c & ~rst;
    assign ex.alu_result    = alu_result_q;
    assign ex.mem_data      = mem_data_q;
    assign ex.mem_dest      = mem_dest_q;
    assign ex.mem_ctrl      = mem_ctrl_q;
    assign ex.mem_valid     = mem_valid_q;
    assign ex.branch_taken  = branch_taken_q;
    assign ex.branch_target = branch_target_q;
    assign ex.flags         = flags_q;

endmodule
